// File: rtl/fredkin_updown_counter.sv
// fredkin_updown_counter
//   Synchronous N-bit modulo-MOD up/down counter whose next-state and flag
//   logic is made only of Fredkin (controlled-swap) gates. Constant 1'b0/1'b1
//   ancillas configure each gate. Garbage outputs are collected in *_unused
//   nets. Each state bit is a T flip-flop: a master level latch, transparent
//   while clk is low, holds the toggle input. The slave stage updates on the
//   rising edge.
//
// Parameters
//   Width N: counter width in bits
//   Modulus: legal range 2..2^N, the count runs from 0 up to modulus-1
//
// Ports
//   clk   in   rising-edge clock
//   rstn  in   synchronous active-low reset
//   en    in   count enable
//   up    in   direction, 1 = increment, 0 = decrement
//   ld    in   synchronous parallel load (wins over en)
//   d     in   load value [N-1:0]
//   q     out  count value [N-1:0]
//   qb    out  per-bit complement of q [N-1:0]
//   tc    out  terminal count: (up & q==MOD-1) | (~up & q==0), combinational

module fredkin_updown_counter #(
    parameter int N   = 4,
    parameter int MOD = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         up,
    input  logic         ld,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic [N-1:0] qb,
    output logic         tc
);

    localparam logic [N-1:0] K_TOP = N'(MOD - 1);
    localparam bit           FULL  = (MOD == (1 << N));

    logic [N-1:0] cy;        // increment carry chain, cy[0] is the +1
    logic [N:0]   bw;        // decrement borrow chain; bw[N] doubles as q==0
    logic [N:0]   ge_top_c;  // ripple compare q >= MOD-1, LSB first
    logic [N-1:0] inc, dec, up_val, dn_val, cnt_val, step_val, ld_val, nxt;
    logic [N-1:0] t, t_m, q_tog;
    logic         ge_top, eq_top, wrap_dn;

    assign cy[0]       = 1'b1;
    assign bw[0]       = 1'b1;
    assign ge_top_c[0] = 1'b1;
    assign ge_top      = ge_top_c[N];

    for (genvar i = 0; i < N; i++) begin : g_bit
        fk_not u_qb (.x(q[i]), .z(qb[i]));

        fk_xor u_inc (.x(q[i]), .y(cy[i]), .z(inc[i]));
        if (i < N - 1) begin : g_cy
            fk_and u_cy (.x(q[i]), .y(cy[i]), .z(cy[i+1]));
        end

        fk_xor u_dec (.x(q[i]), .y(bw[i]), .z(dec[i]));
        fk_and u_bw  (.x(qb[i]), .y(bw[i]), .z(bw[i+1]));

        // Constant compare: a 1 in the constant needs q[i]=1 and the lower
        // bits still >=; a 0 in the constant is satisfied by q[i]=1 outright.
        if (K_TOP[i]) begin : g_gt1
            fk_and u_ge (.x(q[i]), .y(ge_top_c[i]), .z(ge_top_c[i+1]));
        end else begin : g_gt0
            fk_or  u_ge (.x(q[i]), .y(ge_top_c[i]), .z(ge_top_c[i+1]));
        end

        // Up step: wrap to 0 when q >= MOD-1.
        fk_mux u_upv (.s(ge_top),  .a(inc[i]),      .b(1'b0),        .z(up_val[i]));
        // Down step: wrap to MOD-1 when q == 0 or q >= MOD.
        fk_mux u_dnv (.s(wrap_dn), .a(dec[i]),      .b(K_TOP[i]),    .z(dn_val[i]));
        fk_mux u_dir (.s(up),      .a(dn_val[i]),   .b(up_val[i]),   .z(cnt_val[i]));
        fk_mux u_en  (.s(en),      .a(q[i]),        .b(cnt_val[i]),  .z(step_val[i]));
        fk_mux u_ld  (.s(ld),      .a(step_val[i]), .b(d[i]),        .z(ld_val[i]));
        fk_mux u_rst (.s(rstn),    .a(1'b0),        .b(ld_val[i]),   .z(nxt[i]));

        // Toggle request: 1 only where the desired next bit differs from q.
        fk_xor u_t   (.x(q[i]),    .y(nxt[i]),      .z(t[i]));
        // Slave-side toggle applied at the rising edge.
        fk_xor u_tog (.x(t_m[i]),  .y(q[i]),        .z(q_tog[i]));
    end

    if (FULL) begin : g_full
        // With MOD = 2^N no state is >= MOD, so the range checks collapse.
        assign eq_top  = ge_top;
        assign wrap_dn = bw[N];
    end else begin : g_part
        localparam logic [N-1:0] K_MOD = N'(MOD);
        logic [N:0] ge_mod_c;
        logic       ge_mod_n;

        assign ge_mod_c[0] = 1'b1;
        for (genvar j = 0; j < N; j++) begin : g_gm
            if (K_MOD[j]) begin : g_m1
                fk_and u_gm (.x(q[j]), .y(ge_mod_c[j]), .z(ge_mod_c[j+1]));
            end else begin : g_m0
                fk_or  u_gm (.x(q[j]), .y(ge_mod_c[j]), .z(ge_mod_c[j+1]));
            end
        end
        fk_not u_gmn  (.x(ge_mod_c[N]), .z(ge_mod_n));
        // q == MOD-1 is exactly (q >= MOD-1) and not (q >= MOD).
        fk_and u_eqt  (.x(ge_top), .y(ge_mod_n), .z(eq_top));
        fk_or  u_wdn  (.x(bw[N]),  .y(ge_mod_c[N]), .z(wrap_dn));
    end

    fk_mux u_tc (.s(up), .a(bw[N]), .b(eq_top), .z(tc));

    // Master latch: transparent during clk low, opaque while clk is high so
    // the toggle vector seen at the rising edge is the one set up beforehand.
    always_latch begin
        if (!clk) begin
            t_m <= t;
        end
    end

    // Slave stage: reset forces zero from any (even unknown) state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            q <= '0;
        end else begin
            q <= q_tog;
        end
    end

endmodule

// Fredkin controlled swap: p = c, and when c = 1 the a/b outputs swap.
module fredkin (
    input  logic c,
    input  logic a,
    input  logic b,
    output logic p,
    output logic q,
    output logic r
);
    assign p = c;
    assign q = c ? b : a;
    assign r = c ? a : b;
endmodule

// z = ~x  (a = 1, b = 0 ancillas)
module fk_not (
    input  logic x,
    output logic z
);
    logic p_unused, r_unused;
    fredkin u_g (.c(x), .a(1'b1), .b(1'b0), .p(p_unused), .q(z), .r(r_unused));
endmodule

// z = x & y  (a = 0 ancilla)
module fk_and (
    input  logic x,
    input  logic y,
    output logic z
);
    logic p_unused, r_unused;
    fredkin u_g (.c(x), .a(1'b0), .b(y), .p(p_unused), .q(z), .r(r_unused));
endmodule

// z = x | y  (b = 1 ancilla)
module fk_or (
    input  logic x,
    input  logic y,
    output logic z
);
    logic p_unused, r_unused;
    fredkin u_g (.c(x), .a(y), .b(1'b1), .p(p_unused), .q(z), .r(r_unused));
endmodule

// z = s ? b : a
module fk_mux (
    input  logic s,
    input  logic a,
    input  logic b,
    output logic z
);
    logic p_unused, r_unused;
    fredkin u_g (.c(s), .a(a), .b(b), .p(p_unused), .q(z), .r(r_unused));
endmodule

// z = x ^ y, built as a select between y and its Fredkin complement
module fk_xor (
    input  logic x,
    input  logic y,
    output logic z
);
    logic yn, p_unused, r_unused;
    fk_not  u_n (.x(y), .z(yn));
    fredkin u_g (.c(x), .a(y), .b(yn), .p(p_unused), .q(z), .r(r_unused));
endmodule

// File: tb/tb_fredkin_updown_counter.sv
module tb_fredkin_updown_counter;

    logic       clk;
    logic       rstn, en, up, ld;
    logic [3:0] d;
    logic [3:0] q10, qb10, q16, qb16;
    logic       tc10, tc16;

    int vecs = 0;
    int miss = 0;
    int m10  = 0;
    int m16  = 0;

    fredkin_updown_counter #(.N(4), .MOD(10)) dut10 (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .ld(ld), .d(d),
        .q(q10), .qb(qb10), .tc(tc10)
    );

    fredkin_updown_counter #(.N(4), .MOD(16)) dut16 (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .ld(ld), .d(d),
        .q(q16), .qb(qb16), .tc(tc16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rstn;
        bit         ld;
        bit         en;
        bit         up;
        logic [3:0] d;
        logic [3:0] eq;
        bit         etc;
    } vec_t;

    vec_t tbl[$];

    // Reference behaviour from the counting rules, plain integer arithmetic.
    function automatic int ref_next(int cur, int mod, bit r, bit l, bit e,
                                    bit u, int dv);
        if (!r)      return 0;
        if (l)       return dv;
        if (!e)      return cur;
        if (u)       return (cur >= mod - 1) ? 0 : cur + 1;
        return (cur == 0 || cur >= mod) ? mod - 1 : cur - 1;
    endfunction

    function automatic int ref_tc(int cur, int mod, bit u);
        return u ? int'(cur == mod - 1) : int'(cur == 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, got, exp);
        end
    endtask

    task automatic add(input bit r, input bit l, input bit e, input bit u,
                       input int dv, input int eq, input bit etc);
        vec_t v;
        v.rstn = r; v.ld = l; v.en = e; v.up = u;
        v.d = 4'(dv); v.eq = 4'(eq); v.etc = etc;
        tbl.push_back(v);
    endtask

    // Drive one edge's inputs, advance past the edge, check both DUTs
    // against the reference model.
    task automatic apply(input bit r, input bit l, input bit e, input bit u,
                         input logic [3:0] dv);
        rstn = r; ld = l; en = e; up = u; d = dv;
        @(posedge clk);
        #1;
        m10 = ref_next(m10, 10, r, l, e, u, int'(dv));
        m16 = ref_next(m16, 16, r, l, e, u, int'(dv));
        chk("q10_model",  {28'b0, q10},  32'(m10));
        chk("qb10_model", {28'b0, qb10}, 32'(15 - m10));
        chk("tc10_model", {31'b0, tc10}, 32'(ref_tc(m10, 10, u)));
        chk("q16_model",  {28'b0, q16},  32'(m16));
        chk("qb16_model", {28'b0, qb16}, 32'(15 - m16));
        chk("tc16_model", {31'b0, tc16}, 32'(ref_tc(m16, 16, u)));
    endtask

    initial begin
        rstn = 1'b0; ld = 1'b0; en = 1'b0; up = 1'b0; d = 4'd0;

        // Reset with both directions (tc = ~up)
        add(0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0);
        // Count up 0..9,0 with MOD 10
        for (int k = 1; k <= 10; k++) add(1, 0, 1, 1, 0, k % 10, (k % 10) == 9);
        // Count down 9..0,9
        for (int k = 1; k <= 11; k++) add(1, 0, 1, 0, 0, (20 - k) % 10, ((20 - k) % 10) == 0);
        // Hold at 5, then load beats enable, then count
        add(1, 1, 0, 1, 5, 5, 0);
        for (int k = 0; k < 3; k++) add(1, 0, 0, 1, 0, 5, 0);
        add(1, 1, 1, 1, 7, 7, 0);
        add(1, 0, 1, 1, 0, 8, 0);
        // Out-of-range load then up / down
        add(1, 1, 0, 1, 12, 12, 0);
        add(1, 0, 1, 1, 0, 0, 0);
        add(1, 1, 0, 1, 12, 12, 0);
        add(1, 0, 1, 0, 0, 9, 0);
        // Reset overrides load mid-count, then counting resumes from 0
        add(1, 1, 0, 1, 6, 6, 0);
        add(0, 1, 1, 1, 3, 0, 0);
        add(1, 0, 1, 1, 0, 1, 0);

        foreach (tbl[i]) begin
            apply(tbl[i].rstn, tbl[i].ld, tbl[i].en, tbl[i].up, tbl[i].d);
            chk($sformatf("tbl%0d_q", i),  {28'b0, q10},  {28'b0, tbl[i].eq});
            chk($sformatf("tbl%0d_qb", i), {28'b0, qb10}, {28'b0, ~tbl[i].eq});
            chk($sformatf("tbl%0d_tc", i), {31'b0, tc10}, {31'b0, tbl[i].etc});
        end

        // Full-range wrap on the MOD 16 instance
        apply(1, 1, 0, 1, 4'd14);
        chk("wrap16_ld", {28'b0, q16}, 32'd14);
        apply(1, 0, 1, 1, 4'd0);
        chk("wrap16_15", {28'b0, q16}, 32'd15);
        chk("wrap16_tc", {31'b0, tc16}, 32'd1);
        apply(1, 0, 1, 1, 4'd0);
        chk("wrap16_0", {28'b0, q16}, 32'd0);
        chk("wrap16_tc0", {31'b0, tc16}, 32'd0);
        apply(1, 0, 1, 0, 4'd0);
        chk("wrap16_dn15", {28'b0, q16}, 32'd15);
        apply(1, 0, 1, 0, 4'd0);
        chk("wrap16_dn14", {28'b0, q16}, 32'd14);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            apply($urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/fredkin_updown_counter.md
# fredkin_updown_counter

Synchronous N-bit modulo-MOD up/down counter built only from Fredkin gates, with constant ancilla inputs and unconnected garbage outputs. Its state register is a bank of edge-triggered T flip-flops, each a master/slave pair of Fredkin level latches clocked on opposite clock phases. A Fredkin-only next-state network computes each bit's toggle input. The block sits downstream of the reversible T latch and consumes it as the storage primitive, giving the first counting stage of the sequential-circuit library.

## Interface

Parameters:
- N, 4: counter width in bits
- MOD, 16: count modulus; legal range 2..2^N; counts 0..MOD-1

Ports:
- clk  input  1  rising-edge clock; the master latch is transparent while clk is low, the slave while clk is high
- rstn  input  1  synchronous active-low reset, sampled on the rising edge of clk
- en  input  1  count enable
- up  input  1  direction: 1 = increment, 0 = decrement
- ld  input  1  synchronous parallel load
- d  input  N  load value
- q  output  N  count value
- qb  output  N  complement of q, per bit
- tc  output  1  terminal count flag

## Operation

- All next-state and flag logic is Fredkin gate instances only.
  - Fredkin AND/OR/NOT/copy use 1'b0/1'b1 ancillas.
  - No behavioural operators on datapath signals.
- Each bit is a T flip-flop: bit toggles at the edge when its T input is 1. T = current q XOR desired next q, generated in Fredkin logic.
- Action at each rising edge, by priority:
  1. rstn = 0: q <= 0.
  2. ld = 1: q <= d. This happens regardless of en and may load a value ≥ MOD.
  3. en = 1, up = 1: if q ≥ MOD-1 then q <= 0, else q <= q+1.
  4. en = 1, up = 0: if q = 0 or q ≥ MOD then q <= MOD-1, else q <= q-1.
  5. otherwise: q holds, and all T inputs are 0.
- qb = ~q at all times; both come straight from the slave latch outputs.
- tc = (up & q == MOD-1) | (~up & q == 0). It is combinational from q and up and independent of en.
- Arithmetic is unsigned N-bit and there is no overflow output. Wrap behaviour is defined only by the MOD compare above.
- With MOD = 2^N, the compare logic reduces to natural binary wrap. The implementation must still match the rules above.

## Timing

- Latency: q changes one rising edge after the qualifying inputs.
- en, up, ld, d and rstn must be stable from the falling edge before the capturing rising edge until that rising edge, because the master latch samples during clk low.
- Reset values, after the first rising edge with rstn = 0:
  - q = 0
  - qb = all ones
  - tc = ~up
- Before the first reset edge, outputs are undefined (X in simulation).
- Reset mid-count: it overrides ld and en in the same edge, and no partial toggle may occur.
- ld and en both high: the load wins, and no count step is applied on that edge.
- A change of up between edges affects tc immediately and the next count step only.
- tc is valid one combinational delay after q or up changes. It has no registered copy.

## Test plan

- Reset, then count up with N=4, MOD=10, en=1, up=1 → q = 0,1,…,9,0. tc is 1 only while q = 9. qb = ~q on every cycle.
- Count down from reset with MOD=10, up=0 → q = 0,9,8,…,1,0,9. tc is 1 while q = 0.
- Hold and load: en=0 for 3 edges at q = 5 → q stays 5. Then ld=1 with d=7 and en=1 on the same edge → q = 7. The next edge with up=1 → q = 8.
- Out-of-range load: MOD=10, ld with d=12, then up → q = 0. Load d=12 again, then down → q = 9.
- Reset mid-operation: at q = 6, rstn=0 together with ld=1, d=3 → q = 0 and tc = ~up. After rstn returns to 1, counting resumes from 0.
- Full-range wrap: N=4, MOD=16, up → 15 then 0 with tc high at 15. Down → 0 then 15.
